// File: rtl/downsample_hls_deadlock_axis_monitor.sv
// downsample_hls_deadlock_axis_monitor
//
// Deadlock monitor placed beside one HLS dataflow instance with AXI-Stream
// ports. It combines the per-channel AXIS blocked flags with the child
// monitors' block flags (masked by their idle flags). It raises a registered
// `block` once that raw condition has persisted for THRESHOLD cycles. While
// blocked, it records which AXIS channels were involved and how long the
// block has lasted.
//
// Ports
//   clock            sole clock, rising edge
//   reset_n          synchronous active-low reset (beats clear and raw)
//   axis_block_sigs  [NUM_AXIS] per-channel AXIS blocked
//   inst_idle_sigs   [NUM_INST] per-instance idle
//   inst_block_sigs  [NUM_INST] per-instance block from child monitors
//   clear            synchronous clear of FSM, counters and channel mask
//   block            registered deadlock flag (feeds parent monitor)
//   block_chan       [NUM_AXIS] channels seen blocked during the block
//   block_cycles     [CYC_W] cycles spent blocked, saturating

// Per-channel capture cell for block_chan: load on entry, accumulate while
// blocked, hold otherwise.
module downsample_hls_deadlock_axis_monitor_chan_cell (
  input  logic clock,
  input  logic reset_n,
  input  logic clr,
  input  logic entry,
  input  logic stay,
  input  logic axis_blk,
  output logic chan
);
  logic chan_d, chan_q;

  always_comb begin
    chan_d = chan_q;
    if (clr)        chan_d = 1'b0;
    else if (entry) chan_d = axis_blk;
    else if (stay)  chan_d = chan_q | axis_blk;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) chan_q <= 1'b0;
    else          chan_q <= chan_d;
  end

  assign chan = chan_q;
endmodule

module downsample_hls_deadlock_axis_monitor #(
  parameter int NUM_AXIS  = 2,
  parameter int NUM_INST  = 3,
  parameter int THRESHOLD = 1,
  parameter int STICKY    = 0,
  parameter int CYC_W     = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic [NUM_AXIS-1:0] block_chan,
  output logic [CYC_W-1:0]    block_cycles
);
  localparam int CNT_W = $clog2(THRESHOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  state_t             state_d, state_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               block_d, block_q;
  logic [CYC_W-1:0]   cycles_d, cycles_q;
  logic               raw;
  logic               entry, stay;

  // A fully idle design is quiescent, not deadlocked, even if a channel
  // still reports blocked (e.g. an empty input FIFO).
  always_comb begin
    raw = (|axis_block_sigs) | (|(inst_block_sigs & ~inst_idle_sigs));
    if (&inst_idle_sigs) raw = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      // Clear wins over raw; this cycle's raw is not counted.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (raw) begin
            if (THRESHOLD == 1) begin
              state_d = S_BLOCKED;
            end else begin
              state_d = S_PENDING;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        S_PENDING: begin
          if (!raw) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q + CNT_W'(1) == CNT_W'(THRESHOLD)) begin
            state_d = S_BLOCKED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BLOCKED: begin
          cnt_d = '0;
          if (STICKY == 0 && !raw) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Entry/stay are judged on the next state so block and its side info
  // update on the same edge, with no extra cycle of lag.
  assign entry   = (state_d == S_BLOCKED) && (state_q != S_BLOCKED);
  assign stay    = (state_d == S_BLOCKED) && (state_q == S_BLOCKED);
  assign block_d = (state_d == S_BLOCKED);

  always_comb begin
    cycles_d = cycles_q;
    if (clear)      cycles_d = '0;
    else if (entry) cycles_d = CYC_W'(1);
    else if (stay && !(&cycles_q)) cycles_d = cycles_q + CYC_W'(1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      block_q  <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      block_q  <= block_d;
      cycles_q <= cycles_d;
    end
  end

  for (genvar c = 0; c < NUM_AXIS; c++) begin : g_chan
    downsample_hls_deadlock_axis_monitor_chan_cell u_cell (
      .clock    (clock),
      .reset_n  (reset_n),
      .clr      (clear),
      .entry    (entry),
      .stay     (stay),
      .axis_blk (axis_block_sigs[c]),
      .chan     (block_chan[c])
    );
  end

  assign block        = block_q;
  assign block_cycles = cycles_q;
endmodule

// File: tb/tb_downsample_hls_deadlock_axis_monitor.sv
module tb_downsample_hls_deadlock_axis_monitor;
  // Two monitors share the stimulus: A is sticky with a 4-cycle filter,
  // B is non-sticky with a narrow cycle counter to reach saturation.
  localparam int TH_A = 4, STK_A = 1, CW_A = 16;
  localparam int TH_B = 3, STK_B = 0, CW_B = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] axis;
  logic [2:0] iidle, iblk;
  logic       clr;

  logic            block_a, block_b;
  logic [1:0]      chan_a, chan_b;
  logic [CW_A-1:0] cyc_a;
  logic [CW_B-1:0] cyc_b;

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = A, 1 = B.
  int       th_m  [2] = '{TH_A, TH_B};
  int       stk_m [2] = '{STK_A, STK_B};
  int       cmax_m[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  int       run_m [2];
  bit       blk_m [2];
  bit [1:0] chan_m[2];
  int       cyc_m [2];

  always #5 clk = ~clk;

  downsample_hls_deadlock_axis_monitor #(
    .NUM_AXIS(2), .NUM_INST(3), .THRESHOLD(TH_A), .STICKY(STK_A), .CYC_W(CW_A)
  ) dut_a (
    .clock(clk), .reset_n(rst_n), .axis_block_sigs(axis),
    .inst_idle_sigs(iidle), .inst_block_sigs(iblk), .clear(clr),
    .block(block_a), .block_chan(chan_a), .block_cycles(cyc_a)
  );

  downsample_hls_deadlock_axis_monitor #(
    .NUM_AXIS(2), .NUM_INST(3), .THRESHOLD(TH_B), .STICKY(STK_B), .CYC_W(CW_B)
  ) dut_b (
    .clock(clk), .reset_n(rst_n), .axis_block_sigs(axis),
    .inst_idle_sigs(iidle), .inst_block_sigs(iblk), .clear(clr),
    .block(block_b), .block_chan(chan_b), .block_cycles(cyc_b)
  );

  // Model: blocked once raw has been high for TH consecutive counted cycles;
  // side info loads on the rising edge of block and accumulates while held.
  task automatic model_edge();
    bit raw, nb;
    raw = (|axis) || (|(iblk & ~iidle));
    if (&iidle) raw = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n || clr) begin
        run_m[d] = 0; blk_m[d] = 1'b0; chan_m[d] = 2'b00; cyc_m[d] = 0;
      end else begin
        run_m[d] = raw ? ((run_m[d] < 1000) ? run_m[d] + 1 : 1000) : 0;
        nb = (run_m[d] >= th_m[d]) || (stk_m[d] != 0 && blk_m[d]);
        if (nb && !blk_m[d]) begin
          chan_m[d] = axis; cyc_m[d] = 1;
        end else if (nb) begin
          chan_m[d] = chan_m[d] | axis;
          if (cyc_m[d] < cmax_m[d]) cyc_m[d] = cyc_m[d] + 1;
        end
        blk_m[d] = nb;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_block",  {31'd0, block_a}, {31'd0, blk_m[0]});
    chk("a_chan",   {30'd0, chan_a},  {30'd0, chan_m[0]});
    chk("a_cycles", {16'd0, cyc_a},   cyc_m[0]);
    chk("b_block",  {31'd0, block_b}, {31'd0, blk_m[1]});
    chk("b_chan",   {30'd0, chan_b},  {30'd0, chan_m[1]});
    chk("b_cycles", {28'd0, cyc_b},   cyc_m[1]);
  endtask

  // One clock: model the edge, let it happen, sample 1 time unit later.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    // Reset held with every input high.
    rst_n = 1'b0; axis = 2'b11; iidle = 3'b111; iblk = 3'b111; clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_block_a", {31'd0, block_a}, 32'd0);
    end
    rst_n = 1'b1; axis = 2'b00; iidle = 3'b000; iblk = 3'b000; clr = 1'b0;
    step();
    chk("post_rst_cyc_a", {16'd0, cyc_a}, 32'd0);

    // Threshold filter: 3-cycle pulse, 1-cycle gap, then hold.
    axis = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pulse_block_a", {31'd0, block_a}, 32'd0);
    end
    axis = 2'b00;
    step();
    axis = 2'b01;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_early_a", {31'd0, block_a}, 32'd0);
    end
    step();
    chk("hold_block_a", {31'd0, block_a}, 32'd1);
    chk("hold_chan_a", {30'd0, chan_a}, 32'd1);

    // Sticky accumulation on A, then clear.
    axis = 2'b10;
    step();
    chk("acc_chan_a", {30'd0, chan_a}, 32'd3);
    chk("acc_cyc_a", {16'd0, cyc_a}, 32'd2);
    step();
    axis = 2'b00;
    step();
    chk("sticky_block_a", {31'd0, block_a}, 32'd1);
    chk("sticky_cyc_a", {16'd0, cyc_a}, 32'd4);
    clr = 1'b1;
    step();
    chk("clr_block_a", {31'd0, block_a}, 32'd0);
    chk("clr_chan_a", {30'd0, chan_a}, 32'd0);
    clr = 1'b0;

    // Idle suppression, then one instance leaves idle.
    iblk = 3'b111; iidle = 3'b111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_sup_a", {31'd0, block_a}, 32'd0);
    end
    iidle = 3'b110;
    for (int i = 0; i < TH_A - 1; i++) step();
    chk("idle_pre_a", {31'd0, block_a}, 32'd0);
    step();
    chk("idle_blk_a", {31'd0, block_a}, 32'd1);
    iblk = 3'b000; iidle = 3'b000; clr = 1'b1;
    step();
    clr = 1'b0;

    // Saturation and non-sticky exit on B.
    axis = 2'b11;
    for (int i = 0; i < 20; i++) step();
    chk("sat_cyc_b", {28'd0, cyc_b}, 32'd15);
    axis = 2'b00;
    step();
    chk("exit_block_b", {31'd0, block_b}, 32'd0);
    chk("exit_cyc_b", {28'd0, cyc_b}, 32'd15);
    chk("exit_chan_b", {30'd0, chan_b}, 32'd3);
    clr = 1'b1;
    step();
    clr = 1'b0;

    // Clear together with raw while pending restarts the count.
    axis = 2'b01;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < TH_A - 1; i++) step();
    chk("clr_pend_pre_a", {31'd0, block_a}, 32'd0);
    step();
    chk("clr_pend_blk_a", {31'd0, block_a}, 32'd1);

    // Randomized phases against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        axis  = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom);
        iidle = 3'($urandom);
        iblk  = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      end
      clr   = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/downsample_hls_deadlock_axis_monitor.md
# downsample_hls_deadlock_axis_monitor

Parametrised deadlock monitor for HLS-generated dataflow instances with AXI-Stream ports. It watches per-channel AXIS block flags and per-instance block/idle flags, filters transient stalls with a persistence threshold, and raises a registered `block` flag. It also reports which AXIS channels were involved and how long the block has lasted. One instance sits beside each monitored dataflow instance, and its `block` output feeds the parent monitor's block inputs.

## Interface
Parameters:
- `NUM_AXIS`, 2, number of AXIS channels monitored (≥1)
- `NUM_INST`, 3, number of sub-instances monitored (≥1)
- `THRESHOLD`, 1, consecutive raw-block cycles required before `block` asserts (≥1; 1 gives next-cycle assertion)
- `STICKY`, 0, 1 = `block` held until `clear`; 0 = `block` drops when the raw condition drops
- `CYC_W`, 16, width of the `block_cycles` counter

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset_n`  in  1  synchronous, active-low reset
- `axis_block_sigs`  in  NUM_AXIS  per-channel AXIS blocked (full on write / empty on read)
- `inst_idle_sigs`  in  NUM_INST  per-instance idle
- `inst_block_sigs`  in  NUM_INST  per-instance block from child monitors
- `clear`  in  1  synchronous clear of state, counters and captured mask
- `block`  out  1  deadlock detected
- `block_chan`  out  NUM_AXIS  channels seen blocked while `block`=1
- `block_cycles`  out  CYC_W  cycles spent in BLOCKED, saturating

## Operation
- Raw condition, combinational: `raw = (|axis_block_sigs) | (|(inst_block_sigs & ~inst_idle_sigs))`, forced to 0 when `&inst_idle_sigs` is 1 (a fully idle design is not deadlocked).
- Persistence counter `cnt`, width clog2(THRESHOLD+1), saturates at THRESHOLD.
- FSM states: IDLE, PENDING, BLOCKED.
  - IDLE: raw=1 and THRESHOLD=1 → BLOCKED. raw=1 and THRESHOLD>1 → PENDING with cnt=1. Otherwise remain in IDLE with cnt=0.
  - PENDING: raw=0 → IDLE with cnt=0. raw=1 and cnt+1==THRESHOLD → BLOCKED. Otherwise cnt+1.
  - BLOCKED: STICKY=0 and raw=0 → IDLE. STICKY=1 → stay in BLOCKED regardless of raw.
- `clear`=1 in any state → IDLE, cnt=0, block_chan=0, block_cycles=0. clear has priority over raw in the same cycle, and raw is not counted that cycle.
- `block` is a register equal to (next state == BLOCKED). It is not decoded from current state, so there is no extra cycle of lag.
- block_chan:
  - On the entry edge to BLOCKED it loads axis_block_sigs.
  - While in BLOCKED it ORs in axis_block_sigs each cycle.
  - It holds its value after leaving BLOCKED (STICKY=0) until the next entry or clear.
- block_cycles:
  - Loads 1 on the entry edge.
  - Increments each cycle it stays in BLOCKED and saturates at all-ones.
  - Holds its value after exit until the next entry or clear.

## Timing
- Reset (reset_n=0 at an edge) → IDLE, cnt=0, block=0, block_chan=0, block_cycles=0. Reset has priority over clear and raw.
- Reset asserted mid-PENDING or mid-BLOCKED → same reset values at the next edge; no partial state survives.
- Latency: raw first high in cycle t and held → `block`=1 from cycle t+THRESHOLD. With THRESHOLD=1 this is one registered cycle, the same as the single-stage monitor.
- A raw=0 gap of one cycle in PENDING restarts the count from zero.
- STICKY=0: raw falls in cycle u → block=0 from cycle u+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with all inputs at 1 → block=0, block_chan=0, block_cycles=0 throughout and on the first cycle after release.
- Threshold filter, THRESHOLD=4: pulse axis_block_sigs=2'b01 for 3 cycles, gap 1 cycle, then hold → block stays 0 through the pulse; block=1 exactly 4 cycles after the hold begins; block_chan=2'b01.
- Accumulation, STICKY=1: enter BLOCKED on channel 0, then drive 2'b10 while dropping channel 0 → block stays 1, block_chan=2'b11, block_cycles increments each cycle. Assert clear → all outputs 0 on the next cycle.
- Idle suppression, NUM_INST=3: inst_block_sigs=3'b111 with inst_idle_sigs=3'b111 for 10 cycles → block=0. Set inst_idle_sigs=3'b110 → block=1 THRESHOLD cycles later.
- Non-sticky exit and saturation, CYC_W=4, STICKY=0: hold raw for 20 cycles → block_cycles saturates at 15. Drop raw → block=0 next cycle, with block_cycles=15 and block_chan held.
- Simultaneous clear and raw in PENDING → IDLE with cnt=0. A further THRESHOLD raw cycles are then required before block=1.
